elastic_fifo: RTL and testbench
===============================

Name: elastic_fifo

Overview:
- Single-clock, synchronous elastic buffer of DEPTH words that decouples a bursty producer from a consumer.
- Writes and reads are qualified by enables. Occupancy count and empty/full status are exported for flow control.
- Sits between datapath stages, one clock domain only.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out
- ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH = 32 words
- Counter width is fixed at ADDR_WIDTH+1 = 6, range 0..32

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write request; data_in captured on clk rise when accepted
- rd_en  input  1  read request; head word moves to data_out on clk rise when accepted
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data
- buf_empty  output  1  high when counter==0
- buf_full  output  1  high when counter==DEPTH
- counter  output  ADDR_WIDTH+1  current occupancy

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on clk rise, and has priority over wr_en/rd_en.
- Reset state: wr_ptr=0, rd_ptr=0, counter=0, data_out=0, buf_empty=1, buf_full=0. Memory contents are not cleared.
- Accept rules, evaluated on pre-edge state:
  - write accepted = wr_en & !buf_full
  - read accepted = rd_en & !buf_empty
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping from DEPTH-1 to 0.
- Accepted read: data_out <= mem[rd_ptr]; rd_ptr increments with wrap. One-cycle latency: the word is visible on data_out after the same edge that accepts the read.
- No accepted read: data_out holds its previous value.
- Counter update:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- buf_empty and buf_full are combinational decodes of counter, so they update in the same cycle as counter.
- Simultaneous wr_en & rd_en:
  - empty: only the write happens; counter 0->1, data_out unchanged (no fall-through)
  - full: only the read happens; write dropped, counter 32->31
  - otherwise: both happen, counter unchanged
- Write while full: dropped silently; memory and wr_ptr unchanged.
- Read while empty: ignored; data_out, rd_ptr and counter unchanged.
- Ordering: strict FIFO order, including across pointer wrap.
- Reset mid-operation: all queued data is discarded (pointers and counter return to 0) on the reset edge. Operation resumes the cycle after rst deasserts.
- X on wr_en/rd_en outside reset is not supported.

Optional Feature:
- Macro: ELASTIC_FIFO_ERR_FLAGS_EN
- When defined, two extra outputs are added: overflow (1 bit) and underflow (1 bit).
  - overflow: sticky flag, set on the clk edge where wr_en=1 while buf_full=1 and the write is not accepted.
  - underflow: sticky flag, set on the clk edge where rd_en=1 while buf_empty=1.
  - Both flags clear only on rst.
- When undefined: these ports and their logic do not exist; the behaviour of all other ports is identical.

Test Plan:
- Reset then write burst: rst high for 1 cycle, then wr_en=1 with data_in 0x00..0x0E on 15 consecutive edges -> counter 1..15, buf_empty 0 after first write, buf_full 0, data_out stays 0x00.
- Drain: follow the burst with wr_en=0, rd_en=1 -> data_out 0x00,0x01,...,0x0E on successive edges, counter 15..0, buf_empty=1 after 15th read. Further reads leave data_out=0x0E.
- Fill to full: 33 writes of 0x20..0x40 -> counter=32, buf_full=1. Subsequent reads return 0x20..0x3F; 0x40 is never stored (overflow=1 when macro defined).
- Wrap and concurrency: with 10 words stored, hold wr_en=rd_en=1 for 40 cycles -> counter stays 10; output order matches input order across the pointer wrap.
- Boundary simultaneity: both enables at empty -> counter 0->1, data_out unchanged. Both enables at full -> counter 32->31, data_out = oldest word.
- Reset mid-operation: assert rst with 7 words stored -> next edge counter=0, buf_empty=1, data_out=0x00. A read afterward is ignored (underflow=1 if macro defined).

Source files
------------

// File: rtl/elastic_fifo_if.sv
// rtl/elastic_fifo_if.sv - write/read handshake and status bundle for elastic_fifo
// Error flag signals exist only when ELASTIC_FIFO_ERR_FLAGS_EN is defined.
interface elastic_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  buf_empty;
    logic                  buf_full;
    logic [ADDR_WIDTH:0]   counter;
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output wr_en, rd_en, data_in,
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
        input  overflow, underflow,
`endif
        input  data_out, buf_empty, buf_full, counter
    );

    modport slave (
        input  wr_en, rd_en, data_in,
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
        output overflow, underflow,
`endif
        output data_out, buf_empty, buf_full, counter
    );
endinterface

// File: rtl/elastic_fifo.sv
// rtl/elastic_fifo.sv - single-clock elastic FIFO with registered read data
// Define ELASTIC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module elastic_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    elastic_fifo_if.slave  bus
);
    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_wr_acc = bus.wr_en & ~w_full;
    assign w_rd_acc = bus.rd_en & ~w_empty;

    // Storage is left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.buf_empty = w_empty;
    assign bus.buf_full  = w_full;
    assign bus.counter   = r_count;

`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en & w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en & w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_elastic_fifo.sv
// tb/tb_elastic_fifo.sv - directed self-checking bench for elastic_fifo
// Checks overflow/underflow too when ELASTIC_FIFO_ERR_FLAGS_EN is defined.
module tb_elastic_fifo;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    elastic_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

    elastic_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = 8'h00;

        // Reset
        drive(1'b0, 1'b0, 8'h00);
        check("rst_counter", 32'(bus.counter), 32'd0);
        check("rst_empty", 32'(bus.buf_empty), 32'd1);
        check("rst_full", 32'(bus.buf_full), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'h00);
        rst = 1'b0;

        // Write burst 0x00..0x0E
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            check("burst_counter", 32'(bus.counter), 32'(i + 1));
            check("burst_empty", 32'(bus.buf_empty), 32'd0);
            check("burst_full", 32'(bus.buf_full), 32'd0);
            check("burst_dout", 32'(bus.data_out), 32'h00);
        end

        // Drain
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(bus.data_out), 32'(i));
            check("drain_counter", 32'(bus.counter), 32'(14 - i));
        end
        check("drain_empty", 32'(bus.buf_empty), 32'd1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            check("empty_rd_dout", 32'(bus.data_out), 32'h0E);
            check("empty_rd_counter", 32'(bus.counter), 32'd0);
        end
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
        check("underflow_set", 32'(bus.underflow), 32'd1);
        check("overflow_clear", 32'(bus.overflow), 32'd0);
`endif

        // Reset to clear sticky state, then fill to full with 33 writes
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
        check("underflow_rst", 32'(bus.underflow), 32'd0);
`endif
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, 1'b0, 8'(8'h20 + i));
            check("fill_counter", 32'(bus.counter), (i < 32) ? 32'(i + 1) : 32'd32);
        end
        check("fill_full", 32'(bus.buf_full), 32'd1);
        check("fill_empty", 32'(bus.buf_empty), 32'd0);
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
        check("overflow_set", 32'(bus.overflow), 32'd1);
`endif

        // Both enables at full: only the read happens
        drive(1'b1, 1'b1, 8'h99);
        check("both_full_counter", 32'(bus.counter), 32'd31);
        check("both_full_dout", 32'(bus.data_out), 32'h20);
        check("both_full_notfull", 32'(bus.buf_full), 32'd0);
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            check("fill_rd_dout", 32'(bus.data_out), 32'(8'h21 + i));
        end
        check("fill_rd_empty", 32'(bus.buf_empty), 32'd1);

        // Both enables at empty: only the write happens, no fall-through
        drive(1'b1, 1'b1, 8'h50);
        check("both_empty_counter", 32'(bus.counter), 32'd1);
        check("both_empty_dout", 32'(bus.data_out), 32'h3F);
        drive(1'b0, 1'b1, 8'h00);
        check("both_empty_rd", 32'(bus.data_out), 32'h50);
        check("both_empty_cnt0", 32'(bus.counter), 32'd0);

        // Wrap and concurrency with 10 words held
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + i));
        end
        check("wrap_pre_counter", 32'(bus.counter), 32'd10);
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b1, 8'(8'h6A + k));
            check("wrap_dout", 32'(bus.data_out), 32'(8'h60 + k));
            check("wrap_counter", 32'(bus.counter), 32'd10);
        end

        // Leave 7 words, then reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            check("pre_rst_dout", 32'(bus.data_out), 32'(8'h88 + i));
        end
        check("pre_rst_counter", 32'(bus.counter), 32'd7);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hEE);
        check("mid_rst_counter", 32'(bus.counter), 32'd0);
        check("mid_rst_empty", 32'(bus.buf_empty), 32'd1);
        check("mid_rst_dout", 32'(bus.data_out), 32'h00);
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h00);
        check("post_rst_rd_dout", 32'(bus.data_out), 32'h00);
        check("post_rst_rd_counter", 32'(bus.counter), 32'd0);
`ifdef ELASTIC_FIFO_ERR_FLAGS_EN
        check("post_rst_underflow", 32'(bus.underflow), 32'd1);
        check("post_rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        drive(1'b1, 1'b0, 8'hA5);
        check("resume_counter", 32'(bus.counter), 32'd1);
        drive(1'b0, 1'b1, 8'h00);
        check("resume_dout", 32'(bus.data_out), 32'hA5);
        check("resume_empty", 32'(bus.buf_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
